// File: rtl/clk_period_meter32.sv
// clk_period_meter32: measures sig_in half-period in inclk cycles, valid/ready result with timeout
module clk_period_meter32 #(
  parameter int SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        sig_in,
  input  logic        meas_ready,
  output logic [31:0] meas_count,
  output logic        meas_timeout,
  output logic        meas_valid,
  output logic        meas_overrun
);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic cmp;
  logic [31:0] counter;
  logic edge_p;
  logic at_limit;
  logic capture;
  logic load;
  always_comb begin
    edge_p = sync[SYNC_STAGES-1] ^ cmp;
    at_limit = counter == TIMEOUT_CYCLES;
    capture = state == MEASURE && (edge_p || at_limit);
    load = capture && (!meas_valid || meas_ready);
  end
  // An edge coinciding with the limit is a normal result, so edge_p is checked first.
  always_ff @(posedge inclk) begin
    if (!reset) begin
      state <= IDLE;
      sync <= '0;
      cmp <= 1'b0;
      counter <= '0;
      meas_count <= '0;
      meas_timeout <= 1'b0;
      meas_valid <= 1'b0;
      meas_overrun <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      cmp <= sync[SYNC_STAGES-1];
      if (state == IDLE) begin
        if (edge_p) begin
          counter <= 32'd1;
          state <= MEASURE;
        end
      end else if (edge_p) begin
        counter <= 32'd1;
      end else if (at_limit) begin
        counter <= '0;
        state <= IDLE;
      end else begin
        counter <= counter + 32'd1;
      end
      if (load) begin
        meas_count <= edge_p ? counter : TIMEOUT_CYCLES;
        meas_timeout <= !edge_p;
        meas_valid <= 1'b1;
      end else if (meas_ready) begin
        meas_valid <= 1'b0;
      end
      if (capture && meas_valid && !meas_ready) meas_overrun <= 1'b1;
    end
  end
endmodule
